// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core and its program loader.
//   PKG_W      : instruction word width
//   CORE_AW    : instruction memory address width (matches the core PC width)
//   SYNC_BYTE  : frame start byte for the program loader
//   loader_state_t : 3-bit loader FSM encodings (IDLE..RUN); 6 and 7 are unused
package risc_pkg;

    localparam int           PKG_W     = 16;
    localparam int           CORE_AW   = PKG_W - 8;
    localparam logic [7:0]   SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_CHK  = 3'd4,
        ST_RUN  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/risc_prog_loader.sv
// Byte-stream program loader for the 16-bit RISC core.
// Accepts a framed image (SYNC, LEN=N-1, 2*N data bytes high byte first, CHK),
// writes each assembled word to instruction memory starting at address 0,
// then releases the core via cpu_run if the XOR checksum matches.
//
// Handshake: a byte is consumed on a rising edge where in_valid && in_ready.
// in_ready is a pure function of state (high in IDLE..CHK, low in RUN), so the
// loader never stalls a frame; in_valid gaps simply hold the FSM.
//
// Ports:
//   clk          : clock, all state changes on rising edge
//   reset        : asynchronous active-low reset
//   in_data      : stream byte
//   in_valid     : in_data valid
//   in_ready     : loader accepts a byte
//   imem_we      : one-cycle instruction-memory write strobe (registered)
//   imem_addr    : write address (registered)
//   imem_wdata   : write data (registered)
//   cpu_run      : core enable, held until reset
//   err          : sticky checksum error, cleared by the next SYNC
//   state        : current FSM state, for debug
//   words_loaded : words written in the current frame
module risc_prog_loader
    import risc_pkg::*;
#(
    parameter int         W    = PKG_W,
    parameter int         AW   = CORE_AW,
    parameter logic [7:0] SYNC = SYNC_BYTE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [W-1:0]  imem_wdata,
    output logic          cpu_run,
    output logic          err,
    output logic [2:0]    state,
    output logic [AW:0]   words_loaded
);

    loader_state_t st_q, st_d;

    logic [7:0] hi_q;    // high byte of the word being assembled
    logic [7:0] len_q;   // N-1, index of the last word in the frame
    logic [7:0] chk_q;   // running XOR of LEN and data bytes

    logic fire;
    logic last_word;

    assign fire  = in_valid && in_ready;
    assign state = st_q;

    // words_loaded is the index of the word currently being written, so the
    // frame ends when that index reaches LEN (= N-1).
    assign last_word = (words_loaded[AW-1:0] == len_q);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    // Next state and in_ready
    always_comb begin
        st_d     = st_q;
        in_ready = 1'b0;
        case (st_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (fire && in_data == SYNC) st_d = ST_LEN;
            end
            ST_LEN: begin
                in_ready = 1'b1;
                if (fire) st_d = ST_HI;
            end
            ST_HI: begin
                in_ready = 1'b1;
                if (fire) st_d = ST_LO;
            end
            ST_LO: begin
                in_ready = 1'b1;
                if (fire) st_d = last_word ? ST_CHK : ST_HI;
            end
            ST_CHK: begin
                in_ready = 1'b1;
                if (fire) st_d = (in_data == chk_q) ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                st_d = ST_RUN;
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: word assembly, checksum, counters and registered write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q         <= 8'h00;
            len_q        <= 8'h00;
            chk_q        <= 8'h00;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_run      <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            if (fire) begin
                case (st_q)
                    ST_IDLE: begin
                        if (in_data == SYNC) begin
                            err          <= 1'b0;
                            chk_q        <= 8'h00;
                            words_loaded <= '0;
                        end
                    end
                    ST_LEN: begin
                        len_q <= in_data;
                        chk_q <= in_data;
                    end
                    ST_HI: begin
                        hi_q  <= in_data;
                        chk_q <= chk_q ^ in_data;
                    end
                    ST_LO: begin
                        imem_we      <= 1'b1;
                        imem_addr    <= words_loaded[AW-1:0];
                        imem_wdata   <= {hi_q, in_data};
                        words_loaded <= words_loaded + {{AW{1'b0}}, 1'b1};
                        chk_q        <= chk_q ^ in_data;
                    end
                    ST_CHK: begin
                        if (in_data == chk_q) cpu_run <= 1'b1;
                        else                  err     <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
